rp_mtimer: RTL
==============

Name: rp_mtimer

Overview:
Machine timer peripheral and data-bus responder for rp_core. It sits on the core's data bus (req/wen/sel/adr/wdt/rdt/ack) behind an external address decoder. It provides a 64-bit free-running mtime counter with a programmable prescaler, a 64-bit mtimecmp compare register and a level timer interrupt. Reads of mtime are atomic through a hi-word shadow captured on each lo-word read.

Parameters:
DW, 32, bus data width; fixed at 32, other values unsupported
DSW, DW/8, byte select width
AW, 5, bus address width seen by the block (byte address)
PW, 16, prescaler divisor width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
bus_req  input  1  transfer request
bus_wen  input  1  1=write, 0=read
bus_sel  input  DSW  byte select; used for writes only
bus_adr  input  AW  byte address; word index = bus_adr[4:2], bus_adr[1:0] ignored
bus_wdt  input  DW  write data
bus_rdt  output  DW  read data
bus_ack  output  1  responder ready; a transfer completes in a cycle with bus_req && bus_ack
irq_timer  output  1  timer interrupt, level

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst).
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl.en=0, ctrl.div=0, prescaler count=0, shadow=0, bus_rdt=0, bus_ack=0, irq_timer=0.
- bus_ack is registered: 0 in any cycle following a reset cycle, 1 in every other cycle. No wait states.
- Register map (word index): 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 ctrl {div[PW+15:16], en[0]}, 5-7 unmapped.
- Read: bus_rdt is registered and updates the cycle after a read transfer. It holds its value until the next read transfer. Unmapped and unused ctrl bits read 0.
- Atomic read: a read of index 0 returns mtime[31:0] and, in the same cycle, loads shadow<=mtime[63:32]. A read of index 1 returns shadow, not live mtime. A hi read without a preceding lo read returns the stale shadow; this is by design.
- Write: a byte lane is written when bus_sel[i]=1. Writes to unmapped words and to unused ctrl bits are ignored.
- Prescaler:
  - When en=1: if cnt==div then cnt<=0 and tick; else cnt<=cnt+1.
  - div=0 means a tick every cycle.
  - When en=0: cnt holds and there are no ticks.
  - Any write to ctrl clears cnt to 0.
- Counter: on tick, mtime<=mtime+1 modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0, with carry from lo into hi in the same cycle.
- Write/tick collision: a write to mtime lo or hi in a tick cycle wins. The written half takes byte-merged wdt over the pre-tick value, the other half keeps its old value, and that tick is lost. The prescaler still advances normally.
- A read in a tick cycle returns the pre-increment value.
- Interrupt: irq_timer <= (mtime >= mtimecmp), unsigned 64-bit compare on the register values. It asserts one cycle after the condition first holds. It is level-only: it clears only by raising mtimecmp or lowering mtime, with the same one-cycle delay. It is independent of en.
- Reset mid-transfer: the transfer is discarded, with no write and no rdt update. All state returns to reset values in the cycle after rst is sampled high.

Decomposition:
- Package rp_mtimer_pkg holds:
  - word-index constants MTIME_LO, MTIME_HI, MTIMECMP_LO, MTIMECMP_HI, CTRL;
  - packed struct ctrl_t {div, en};
  - reset constant for mtimecmp.
- One sub-module, rp_prescaler: inputs clk, rst, en, div, clr; output tick. It holds cnt.
- Byte-merge logic stays in a package function.

Test Plan:
- Reset and idle: hold rst 2 cycles, release -> bus_ack=0 for the first cycle after reset, 1 after; bus_rdt=0; irq_timer=0; reading index 3 returns FFFF_FFFF.
- Prescaler: write ctrl=0x0003_0001 (div=3, en=1), wait 40 cycles, read lo -> mtime=10 (±1 per the documented tick phase); ctrl with en=0 -> mtime frozen across 100 cycles.
- Carry/wrap: write hi=0, lo=FFFF_FFFF, div=0, en=1 -> after 1 tick read hi/lo = 1/0. Write hi=lo=FFFF_FFFF -> next tick gives 0/0.
- Atomic read: mtime=0x0000_0000_FFFF_FFFE, div=0, read lo, then read hi 3 cycles later -> lo=FFFF_FFFE (±0) and hi=0, the shadow value, not live 1.
- Interrupt: mtimecmp=20, mtime=0, div=0, en=1 -> irq_timer rises exactly one cycle after mtime reaches 20. Write mtimecmp_lo=1000 -> irq falls one cycle later.
- Collision and byte select: write lo with sel=4'b0010, wdt=0x0000_AB00 in a tick cycle with lo=0x0000_0010 -> lo=0x0000_AB10 with no increment that cycle. A write to index 6 leaves all registers unchanged; a read of index 6 returns 0.

Source files
------------

// File: rtl/rp_mtimer_pkg.sv
// Shared constants, register image types and helpers for the rp_mtimer machine timer.
package rp_mtimer_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned DSW  = DW / 8;
    localparam int unsigned AW   = 5;
    localparam int unsigned PW   = 16;
    localparam int unsigned IDXW = AW - 2;
    localparam int unsigned TW   = 64;

    // Word indices on the data bus
    localparam logic [IDXW-1:0] MTIME_LO    = IDXW'(0);
    localparam logic [IDXW-1:0] MTIME_HI    = IDXW'(1);
    localparam logic [IDXW-1:0] MTIMECMP_LO = IDXW'(2);
    localparam logic [IDXW-1:0] MTIMECMP_HI = IDXW'(3);
    localparam logic [IDXW-1:0] CTRL        = IDXW'(4);

    typedef struct packed {
        logic [PW-1:0] div;
        logic          en;
    } ctrl_t;

    localparam logic [TW-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam ctrl_t         CTRL_RST     = '{div: '0, en: 1'b0};

    // Replace the byte lanes of old_w selected by sel with the lanes of new_w
    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0]  old_w,
        input logic [DW-1:0]  new_w,
        input logic [DSW-1:0] sel
    );
        logic [DW-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(DSW); i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Bus view of ctrl: div in the upper half, en in bit 0, everything else 0
    function automatic logic [DW-1:0] ctrl_to_word(input ctrl_t c);
        return {c.div, {(DW-PW-1){1'b0}}, c.en};
    endfunction

endpackage

// File: rtl/rp_prescaler.sv
// Tick generator: one tick every div+1 enabled cycles; clr restarts the count.
module rp_prescaler
    import rp_mtimer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] div,
    input  logic          clr,
    output logic          tick
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // tick is combinational so the counter can use it in the same cycle
    always_comb begin
        tick  = en && (cnt_q == div);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rp_mtimer.sv
// Machine timer: 64-bit prescaled mtime, mtimecmp, level interrupt and a
// zero-wait-state data-bus responder with an atomic hi-word read shadow.
module rp_mtimer
    import rp_mtimer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           bus_req,
    input  logic           bus_wen,
    input  logic [DSW-1:0] bus_sel,
    input  logic [AW-1:0]  bus_adr,
    input  logic [DW-1:0]  bus_wdt,
    output logic [DW-1:0]  bus_rdt,
    output logic           bus_ack,
    output logic           irq_timer
);

    logic [TW-1:0]   mtime_q,    mtime_d;
    logic [TW-1:0]   mtimecmp_q, mtimecmp_d;
    ctrl_t           ctrl_q,     ctrl_d;
    logic [DW-1:0]   shadow_q,   shadow_d;
    logic [DW-1:0]   rdt_q,      rdt_d;
    logic            ack_q,      ack_d;
    logic            irq_q,      irq_d;

    logic            xfer;
    logic            wr;
    logic            rd;
    logic            ctrl_wr;
    logic            tick;
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   ctrl_wr_word;
    logic            unused_bits;

    assign xfer         = bus_req && ack_q;
    assign wr           = xfer && bus_wen;
    assign rd           = xfer && !bus_wen;
    assign idx          = bus_adr[AW-1:2];
    assign ctrl_wr      = wr && (idx == CTRL);
    assign ctrl_wr_word = byte_merge(ctrl_to_word(ctrl_q), bus_wdt, bus_sel);
    assign unused_bits  = ^{bus_adr[1:0], ctrl_wr_word[DW-PW-1:1]};

    rp_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q.en),
        .div  (ctrl_q.div),
        .clr  (ctrl_wr),
        .tick (tick)
    );

    // Next-state: a write to an mtime half overrides (and drops) a coincident tick
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        shadow_d   = shadow_q;
        rdt_d      = rdt_q;
        ack_d      = 1'b1;
        irq_d      = (mtime_q >= mtimecmp_q);

        if (tick) begin
            mtime_d = mtime_q + TW'(1);
        end

        if (wr) begin
            case (idx)
                MTIME_LO: begin
                    mtime_d = {mtime_q[TW-1:DW], byte_merge(mtime_q[DW-1:0], bus_wdt, bus_sel)};
                end
                MTIME_HI: begin
                    mtime_d = {byte_merge(mtime_q[TW-1:DW], bus_wdt, bus_sel), mtime_q[DW-1:0]};
                end
                MTIMECMP_LO: begin
                    mtimecmp_d[DW-1:0] = byte_merge(mtimecmp_q[DW-1:0], bus_wdt, bus_sel);
                end
                MTIMECMP_HI: begin
                    mtimecmp_d[TW-1:DW] = byte_merge(mtimecmp_q[TW-1:DW], bus_wdt, bus_sel);
                end
                CTRL: begin
                    ctrl_d.div = ctrl_wr_word[DW-1:DW-PW];
                    ctrl_d.en  = ctrl_wr_word[0];
                end
                default: begin
                end
            endcase
        end

        if (rd) begin
            case (idx)
                MTIME_LO: begin
                    rdt_d    = mtime_q[DW-1:0];
                    shadow_d = mtime_q[TW-1:DW];
                end
                MTIME_HI:    rdt_d = shadow_q;
                MTIMECMP_LO: rdt_d = mtimecmp_q[DW-1:0];
                MTIMECMP_HI: rdt_d = mtimecmp_q[TW-1:DW];
                CTRL:        rdt_d = ctrl_to_word(ctrl_q);
                default:     rdt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            ctrl_q     <= CTRL_RST;
            shadow_q   <= '0;
            rdt_q      <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    assign bus_rdt   = rdt_q;
    assign bus_ack   = ack_q;
    assign irq_timer = irq_q;

endmodule
